// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing controller: ALUC codes, result-mux
// encodings, FSM states and the ALUC-to-control-line decode.
package alu_share_pkg;

   localparam logic [3:0] ALUC_ADD     = 4'b0000;
   localparam logic [3:0] ALUC_SUB     = 4'b0100;
   localparam logic [3:0] ALUC_AND     = 4'b0001;
   localparam logic [3:0] ALUC_OR      = 4'b0101;
   localparam logic [3:0] ALUC_XOR     = 4'b0010;
   localparam logic [3:0] ALUC_LUI     = 4'b0110;
   localparam logic [3:0] ALUC_SLL     = 4'b0011;
   localparam logic [3:0] ALUC_SRL     = 4'b0111;
   localparam logic [3:0] ALUC_SRA     = 4'b1111;
   localparam logic [3:0] ALUC_ILLEGAL = 4'b1011;

   localparam logic [1:0] SEL_LOGIC  = 2'b00;
   localparam logic [1:0] SEL_ADDSUB = 2'b01;
   localparam logic [1:0] SEL_XORLUI = 2'b10;
   localparam logic [1:0] SEL_SHIFT  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0] sel;
      logic       lsel;
      logic       sub;
      logic       sh_opr;
      logic       sh_cntr;
      logic       is_add;
      logic       err;
   } alu_ctrl_t;

   // Bit 2 doubles as sub / or / lui / right-shift select; bit 3 only matters for shifts.
   function automatic alu_ctrl_t decode_aluc(input logic [3:0] aluc);
      alu_ctrl_t c;
      c = '0;
      case (aluc[1:0])
         2'b00: begin
            c.sel    = SEL_ADDSUB;
            c.sub    = aluc[2];
            c.is_add = ~aluc[2];
         end
         2'b01: begin
            c.sel  = SEL_LOGIC;
            c.lsel = aluc[2];
         end
         2'b10: begin
            c.sel  = SEL_XORLUI;
            c.lsel = aluc[2];
         end
         default: begin
            if (aluc == ALUC_ILLEGAL) begin
               c.err = 1'b1;
            end else begin
               c.sel     = SEL_SHIFT;
               c.sh_cntr = aluc[2];
               c.sh_opr  = aluc[3];
            end
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bus between the issue-side requesters and the ALU-sharing controller.
interface alu_share_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NREQ       = 2,
   parameter int ID_W       = 2
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   logic [4*NREQ-1:0]          req_op;
   logic [DATA_WIDTH*NREQ-1:0] req_a;
   logic [DATA_WIDTH*NREQ-1:0] req_b;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [ID_W-1:0]            rsp_id;
   logic [DATA_WIDTH-1:0]      rsp_data;
   logic                       rsp_carry;
   logic                       rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping to
// the lowest index; one-hot grant plus its binary index.
module alu_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] idx
);
   logic            hi_any;
   logic [ID_W-1:0] hi_idx;
   logic [ID_W-1:0] lo_idx;
   logic            any_req;

   // Descending scan so the lowest qualifying index is the one left standing.
   always_comb begin
      hi_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = ID_W'(i);
            if (ID_W'(i) >= ptr) begin
               hi_any = 1'b1;
               hi_idx = ID_W'(i);
            end
         end
      end
      idx = hi_any ? hi_idx : lo_idx;
   end

   assign any_req = en && (|req);

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
         assign grant[gi] = any_req && (idx == ID_W'(gi));
      end
   endgenerate
endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between NREQ requesters: arbitrate, register
// the operation, drive the ALU for one cycle, then hold the result until taken.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NREQ       = 2,
   parameter int ID_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_share_ctrl_if.slave       bus,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic                  alu_sub,
   output logic                  alu_sh_opr,
   output logic                  alu_sh_cntr,
   output logic [1:0]            alu_sel,
   output logic                  alu_lsel,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_carry
);
   state_t                state_reg, state_next;
   logic [ID_W-1:0]       rr_ptr_reg, id_reg, rsp_id_reg, grant_idx;
   logic [NREQ-1:0]       grant;
   logic                  grant_any, arb_en;
   logic [3:0]            op_reg, sel_op;
   logic [DATA_WIDTH-1:0] a_reg, b_reg, sel_a, sel_b, rsp_data_reg;
   logic                  rsp_carry_reg, rsp_err_reg;
   alu_ctrl_t             ctrl;

   // Gated by rst_n so no requester sees an acceptance that reset then discards.
   assign arb_en = rst_n && (state_reg == IDLE);

   alu_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_reg),
      .en    (arb_en),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign grant_any     = |grant;
   assign bus.req_ready = grant;
   assign ctrl          = decode_aluc(op_reg);

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_op = bus.req_op[4*i +: 4];
            sel_a  = bus.req_a[DATA_WIDTH*i +: DATA_WIDTH];
            sel_b  = bus.req_b[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      alu_a       = '0;
      alu_b       = '0;
      alu_sub     = 1'b0;
      alu_sh_opr  = 1'b0;
      alu_sh_cntr = 1'b0;
      alu_sel     = SEL_LOGIC;
      alu_lsel    = 1'b0;
      case (state_reg)
         IDLE: if (grant_any) state_next = EXEC;
         EXEC: begin
            alu_a       = a_reg;
            alu_b       = b_reg;
            alu_sub     = ctrl.sub;
            alu_sh_opr  = ctrl.sh_opr;
            alu_sh_cntr = ctrl.sh_cntr;
            alu_sel     = ctrl.sel;
            alu_lsel    = ctrl.lsel;
            state_next  = RESP;
         end
         RESP: if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_reg    <= '0;
         op_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= '0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
         rsp_carry_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
      end else begin
         if (grant_any) begin
            op_reg     <= sel_op;
            a_reg      <= sel_a;
            b_reg      <= sel_b;
            id_reg     <= grant_idx;
            rr_ptr_reg <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
         end
         if (state_reg == EXEC) begin
            rsp_data_reg  <= ctrl.err ? '0 : alu_result;
            rsp_carry_reg <= ctrl.is_add & alu_carry;
            rsp_err_reg   <= ctrl.err;
            rsp_id_reg    <= id_reg;
         end
      end
   end

   assign bus.rsp_valid = (state_reg == RESP);
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_carry = rsp_carry_reg;
   assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU on the alu_* lines, scoreboard of
// expected responses pushed at grant and checked by a negedge monitor.
module tb_alu_share_ctrl;
   import alu_share_pkg::*;

   localparam int DW = 32;
   localparam int NR = 2;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic          alu_sub, alu_sh_opr, alu_sh_cntr, alu_lsel, alu_carry;
   logic [1:0]    alu_sel;
   logic [32:0]   alu_sum;

   alu_share_ctrl_if #(.DATA_WIDTH(DW), .NREQ(NR), .ID_W(IW)) bus ();

   alu_share_ctrl #(.DATA_WIDTH(DW), .NREQ(NR), .ID_W(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sub     (alu_sub),
      .alu_sh_opr  (alu_sh_opr),
      .alu_sh_cntr (alu_sh_cntr),
      .alu_sel     (alu_sel),
      .alu_lsel    (alu_lsel),
      .alu_result  (alu_result),
      .alu_carry   (alu_carry)
   );

   // The shared ALU as the parent would instantiate it.
   always_comb begin
      alu_result = '0;
      alu_carry  = 1'b0;
      alu_sum    = '0;
      case (alu_sel)
         2'b00: alu_result = alu_lsel ? (alu_a | alu_b) : (alu_a & alu_b);
         2'b01: begin
            alu_sum = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                              : ({1'b0, alu_a} + {1'b0, alu_b});
            alu_result = alu_sum[31:0];
            alu_carry  = alu_sum[32];
         end
         2'b10: alu_result = alu_lsel ? {alu_b[15:0], 16'h0000} : (alu_a ^ alu_b);
         default: begin
            if (alu_sh_cntr)
               alu_result = alu_sh_opr ? DW'($signed(alu_b) >>> alu_a[4:0]) : (alu_b >> alu_a[4:0]);
            else
               alu_result = alu_b << alu_a[4:0];
         end
      endcase
   end

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        carry;
      logic        err;
      logic [31:0] a;
      logic [31:0] b;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   chk_m = 0, err_m = 0, chk_s = 0, err_s = 0;
   int   cyc = 0;
   int   model_ptr = 0;
   int   mon_pick;
   bit   hold_prev = 1'b0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] d, output logic c, output logic e);
      logic [32:0] s;
      d = '0; c = 1'b0; e = 1'b0;
      casez (op)
         4'b?000: begin s = {1'b0, a} + {1'b0, b}; d = s[31:0]; c = s[32]; end
         4'b?100: d = a - b;
         4'b?001: d = a & b;
         4'b?101: d = a | b;
         4'b?010: d = a ^ b;
         4'b?110: d = b << 16;
         4'b0011: d = b << a[4:0];
         4'b0111: d = b >> a[4:0];
         4'b1111: d = $unsigned($signed(b) >>> a[4:0]);
         default: e = 1'b1;
      endcase
   endfunction

   // Monitor: arbitration, ALU drive and response checks against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         model_ptr = 0;
         hold_prev = 1'b0;
      end else begin
         if (bus.req_ready != 0 || (exp_q.size() == 0 && bus.req_valid != 0)) begin
            mon_pick = -1;
            for (int k = 0; k < NR; k++)
               if (mon_pick < 0 && bus.req_valid[(model_ptr + k) % NR]) mon_pick = (model_ptr + k) % NR;
            chk_s++;
            if (mon_pick < 0 || bus.req_ready !== NR'(1 << mon_pick)) begin
               err_s++;
               $display("FAIL grant actual=%b required_idx=%0d req_valid=%b", bus.req_ready, mon_pick, bus.req_valid);
            end else begin
               ref_alu(bus.req_op[4*mon_pick +: 4], bus.req_a[32*mon_pick +: 32], bus.req_b[32*mon_pick +: 32],
                       mon_e.data, mon_e.carry, mon_e.err);
               mon_e.id  = mon_pick;
               mon_e.a   = bus.req_a[32*mon_pick +: 32];
               mon_e.b   = bus.req_b[32*mon_pick +: 32];
               mon_e.due = cyc + 2;
               exp_q.push_back(mon_e);
               model_ptr = (mon_pick + 1) % NR;
               $display("grant id=%0d op=%h a=%h b=%h", mon_pick, bus.req_op[4*mon_pick +: 4], mon_e.a, mon_e.b);
            end
         end
         chk_s++;
         if (exp_q.size() != 0 && cyc == exp_q[0].due - 1) begin
            if (alu_a !== exp_q[0].a || alu_b !== exp_q[0].b) begin
               err_s++;
               $display("FAIL alu_operands actual=%h/%h required=%h/%h", alu_a, alu_b, exp_q[0].a, exp_q[0].b);
            end
         end else if ({alu_a, alu_b, alu_sub, alu_sh_opr, alu_sh_cntr, alu_sel, alu_lsel} != '0) begin
            err_s++;
            $display("FAIL alu_idle actual a=%h b=%h sel=%b required all zero", alu_a, alu_b, alu_sel);
         end
         if (bus.rsp_valid) begin
            chk_s++;
            if (exp_q.size() == 0) begin
               err_s++;
               $display("FAIL rsp_unexpected actual id=%0d data=%h required no response", bus.rsp_id, bus.rsp_data);
            end else begin
               mon_e = exp_q[0];
               if ((!hold_prev && cyc != mon_e.due) || bus.req_ready != 0 ||
                   bus.rsp_id !== IW'(mon_e.id) || bus.rsp_data !== mon_e.data ||
                   bus.rsp_carry !== mon_e.carry || bus.rsp_err !== mon_e.err) begin
                  err_s++;
                  $display("FAIL rsp actual cyc=%0d id=%0d data=%h c=%b e=%b rdy=%b required cyc=%0d id=%0d data=%h c=%b e=%b rdy=0",
                           cyc, bus.rsp_id, bus.rsp_data, bus.rsp_carry, bus.rsp_err, bus.req_ready,
                           mon_e.due, mon_e.id, mon_e.data, mon_e.carry, mon_e.err);
               end
               if (bus.rsp_ready) begin
                  $display("rsp id=%0d data=%h carry=%b err=%b", bus.rsp_id, bus.rsp_data, bus.rsp_carry, bus.rsp_err);
                  void'(exp_q.pop_front());
                  hold_prev = 1'b0;
               end else begin
                  hold_prev = 1'b1;
               end
            end
         end else if (exp_q.size() != 0 && cyc == exp_q[0].due) begin
            chk_s++;
            err_s++;
            $display("FAIL rsp_missing actual rsp_valid=0 required rsp_valid=1 id=%0d", exp_q[0].id);
         end
      end
   end

   task automatic mchk(input string name, input logic [63:0] act, input logic [63:0] req);
      chk_m++;
      if (act !== req) begin
         err_m++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic load(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_op[4*i +: 4] = op;
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
      bus.req_valid[i]      = 1'b1;
   endtask

   task automatic step(output logic [NR-1:0] g);
      @(negedge clk);
      g = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (g[i]) bus.req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      logic [NR-1:0] g;
      int n;
      n = 0;
      bus.rsp_ready = 1'b1;
      while ((bus.req_valid != 0 || exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
         step(g);
         n++;
      end
      if (n >= 200) begin
         chk_m++;
         err_m++;
         $display("FAIL drain_timeout actual=pending required=idle");
      end
   endtask

   task automatic pulse_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_zero(input string name);
      mchk({name, "_rsp"}, {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_err}, '0);
      mchk({name, "_data"}, {32'h0, bus.rsp_data}, '0);
      mchk({name, "_alu"}, {alu_a, alu_b} | {59'h0, alu_sub, alu_sh_opr, alu_sh_cntr, alu_sel, alu_lsel}, '0);
   endtask

   logic [NR-1:0] g;
   int            gid_q[$];
   int            gstep_q[$];

   initial begin
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      rst_n         = 1'b0;
      @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // Add with carry-out
      load(0, ALUC_ADD, 32'hFFFF_FFFF, 32'h1);
      drain();

      // Two requesters held valid alternate, one grant every third cycle
      pulse_reset();
      load(0, ALUC_SUB, $urandom, $urandom);
      load(1, ALUC_XOR, $urandom, $urandom);
      for (int s = 0; s < 12; s++) begin
         step(g);
         if (g != 0) begin
            gid_q.push_back(g[1] ? 1 : 0);
            gstep_q.push_back(s);
            for (int i = 0; i < NR; i++) if (g[i]) load(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
         end
      end
      mchk("rr_count", gid_q.size(), 4);
      for (int k = 0; k < gid_q.size() && k < 4; k++) begin
         mchk("rr_id", gid_q[k], k % 2);
         mchk("rr_spacing", gstep_q[k], 3 * k);
      end
      drain();

      // Shifts
      load(0, ALUC_SRA, 32'd4, 32'h8000_0000);  drain();
      load(0, ALUC_SRL, 32'd4, 32'h8000_0000);  drain();
      load(0, ALUC_SLL, 32'd31, 32'h1);         drain();

      // Response back-pressure with a competing request
      bus.rsp_ready = 1'b0;
      load(0, ALUC_OR, 32'h1234_0000, 32'h0000_5678);
      step(g);
      mchk("bp_grant0", g, 2'b01);
      load(1, ALUC_LUI, 32'h0, 32'h0000_ABCD);
      step(g);
      for (int k = 0; k < 5; k++) begin
         step(g);
         mchk("bp_hold_noready", g, 2'b00);
      end
      bus.rsp_ready = 1'b1;
      step(g);
      mchk("bp_accept_cycle", g, 2'b00);
      step(g);
      mchk("bp_grant1_after", g, 2'b10);
      drain();

      // Illegal ALUC then a normal op
      load(0, ALUC_ILLEGAL, 32'd5, 32'd3);  drain();
      load(1, ALUC_ADD, 32'd5, 32'd3);      drain();

      // Reset during EXEC
      load(0, ALUC_ADD, $urandom, $urandom);
      step(g);
      mchk("rst_pre_grant", g, 2'b01);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_zero("rst_exec");
      rst_n = 1'b1;
      load(0, ALUC_AND, $urandom, $urandom);
      load(1, ALUC_AND, $urandom, $urandom);
      step(g);
      mchk("rst_ptr_zero", g, 2'b01);
      drain();

      // Random traffic with random back-pressure and request withdrawal
      for (int s = 0; s < 400; s++) begin
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NR; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
               load(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
            else if (bus.req_valid[i] && $urandom_range(0, 24) == 0)
               bus.req_valid[i] = 1'b0;
         end
         step(g);
      end
      drain();
      mchk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", chk_m + chk_s, err_m + err_s);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule
